// File: rtl/amp_i2c_arbiter.sv
// amp_i2c_arbiter
// Shares one byte-write I2C engine between two register-write requesters
// (port 0: boot/config sequencer, port 1: runtime volume/mute control).
// Provides round-robin arbitration, one-shot engine start, NACK retry,
// transaction timeout and a bus-free gap between engine transactions.
//
// Ports:
//   clk_in, reset                 clock, synchronous active-high reset
//   reqN_valid/addr/data          request from port N, held until reqN_grant
//   reqN_grant/done/err           1-cycle pulses back to port N
//   eng_start/addr/data           command to the byte-write engine
//   eng_busy/done/nack            status from the byte-write engine
//   busy                          arbiter is not idle
module amp_i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_grant,
  output logic       req0_done,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_grant,
  output logic       req1_done,
  output logic       req1_err,
  output logic       eng_start,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_data,
  input  logic       eng_busy,
  input  logic       eng_done,
  input  logic       eng_nack,
  output logic       busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam int unsigned RTY_W = 3;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [GAP_W-1:0] gap_q;
  logic [RTY_W-1:0] retry_cnt_q;
  logic             retry_pend_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [7:0]       eng_addr_q;
  logic [7:0]       eng_data_q;
  logic             eng_start_q;
  logic             grant0_q, grant1_q;
  logic             done0_q, done1_q;
  logic             err0_q, err1_q;
  logic             busy_q;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  logic any_req_c;
  logic win_c;
  assign any_req_c = req0_valid | req1_valid;
  assign win_c     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      gap_q        <= '0;
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      eng_addr_q   <= '0;
      eng_data_q   <= '0;
      eng_start_q  <= 1'b0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      eng_start_q <= 1'b0;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (any_req_c && !eng_busy) begin
            owner_q      <= win_c;
            last_grant_q <= win_c;
            retry_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
            eng_addr_q   <= win_c ? req1_addr : req0_addr;
            eng_data_q   <= win_c ? req1_data : req0_data;
            grant0_q     <= ~win_c;
            grant1_q     <= win_c;
            eng_start_q  <= 1'b1;
            timer_q      <= '0;
            busy_q       <= 1'b1;
            state_q      <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // A completion wins over a timeout landing on the same cycle.
          if (eng_done) begin
            gap_q   <= '0;
            state_q <= ST_GAP;
            if (!eng_nack) begin
              done0_q <= ~owner_q;
              done1_q <= owner_q;
            end else if (retry_cnt_q < RTY_MAX) begin
              retry_cnt_q  <= retry_cnt_q + RTY_W'(1);
              retry_pend_q <= 1'b1;
            end else begin
              err0_q <= ~owner_q;
              err1_q <= owner_q;
            end
          end else if (timer_q == TMR_LAST) begin
            err0_q       <= ~owner_q;
            err1_q       <= owner_q;
            retry_pend_q <= 1'b0;
            gap_q        <= '0;
            state_q      <= ST_GAP;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        ST_GAP: begin
          // Hold the bus quiet for GAP_CYC cycles and until the engine has
          // actually stopped (it may still be running after a timeout).
          if (gap_q == GAP_LAST) begin
            if (!eng_busy) begin
              if (retry_pend_q) begin
                retry_pend_q <= 1'b0;
                eng_start_q  <= 1'b1;
                timer_q      <= '0;
                state_q      <= ST_WAIT;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_grant = grant0_q;
  assign req0_done  = done0_q;
  assign req0_err   = err0_q;
  assign req1_grant = grant1_q;
  assign req1_done  = done1_q;
  assign req1_err   = err1_q;
  assign eng_start  = eng_start_q;
  assign eng_addr   = eng_addr_q;
  assign eng_data   = eng_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_amp_i2c_arbiter.sv
// tb_amp_i2c_arbiter
// Self-checking bench for amp_i2c_arbiter with a behavioural byte-write
// engine. Expected grants/results are queued when a request is driven and
// popped when the arbiter grants and completes it.
module tb_amp_i2c_arbiter;

  localparam int unsigned TO    = 16;
  localparam int unsigned GAP   = 8;
  localparam int unsigned RETRY = 2;

  typedef struct {
    int         port;
    logic [7:0] addr;
    logic [7:0] data;
    bit         err;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_addr  = 8'h00;
  logic [7:0] req0_data  = 8'h00;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_addr  = 8'h00;
  logic [7:0] req1_data  = 8'h00;
  logic       req0_grant, req0_done, req0_err;
  logic       req1_grant, req1_done, req1_err;
  logic       eng_start;
  logic [7:0] eng_addr, eng_data;
  logic       eng_busy;
  logic       eng_done = 1'b0;
  logic       eng_nack = 1'b0;
  logic       busy;
  logic       busy_m    = 1'b0;
  logic       busy_hold = 1'b0;

  assign eng_busy = busy_m | busy_hold;

  amp_i2c_arbiter #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP), .MAX_RETRY(RETRY)) dut (
    .clk_in(clk_in), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_grant(req0_grant), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_grant(req1_grant), .req1_done(req1_done), .req1_err(req1_err),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_data(eng_data),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  // Engine model: done eng_lat cycles after the start it sees.
  int eng_lat      = 10;
  int nack_plan    = 0;
  int nack_arm     = 0;
  bit nack_forever = 1'b0;
  bit eng_mute     = 1'b0;
  int e_cnt        = -1;
  int e_left       = 0;
  int e_arm_seen   = 0;
  always @(negedge clk_in) begin
    eng_done = 1'b0;
    eng_nack = 1'b0;
    if (e_arm_seen != nack_arm) begin
      e_arm_seen = nack_arm;
      e_left     = nack_plan;
    end
    if (reset) begin
      e_cnt  = -1;
      busy_m = 1'b0;
    end else if (eng_start && !eng_mute) begin
      e_cnt  = eng_lat;
      busy_m = 1'b1;
    end else if (e_cnt > 0) begin
      e_cnt--;
      if (e_cnt == 0) begin
        eng_done = 1'b1;
        eng_nack = nack_forever || (e_left > 0);
        if (e_left > 0) e_left--;
        busy_m = 1'b0;
        e_cnt  = -1;
      end
    end
  end

  // Pulse counters.
  int c_start = 0, c_g0 = 0, c_g1 = 0, c_d0 = 0, c_d1 = 0, c_e0 = 0, c_e1 = 0;
  int t_start = 0, t_start_prev = 0;
  always @(negedge clk_in) begin
    if (eng_start) begin c_start++; t_start_prev = t_start; t_start = cyc; end
    if (req0_grant) c_g0++;
    if (req1_grant) c_g1++;
    if (req0_done)  c_d0++;
    if (req1_done)  c_d1++;
    if (req0_err)   c_e0++;
    if (req1_err)   c_e1++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_grant(output int port, output int at);
    port = -1;
    at   = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (req0_grant || req1_grant) begin
        port = (req0_grant && req1_grant) ? 2 : (req1_grant ? 1 : 0);
        at   = cyc;
        return;
      end
    end
  endtask

  task automatic wait_result(output int port, output bit is_err, output int at);
    port   = -1;
    is_err = 1'b0;
    at     = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (req0_done || req1_done || req0_err || req1_err) begin
        port   = (req1_done || req1_err) ? 1 : 0;
        is_err = req0_err || req1_err;
        at     = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_tests++;
    if ({req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err, eng_start, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err, eng_start, busy});
    end
    n_tests++;
    if ({eng_addr, eng_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h want 00/00", eng_addr, eng_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    exp_t e; int p, s, at, t_low; bit er;
    exp_q.push_back('{0, 8'h40, 8'h18, 1'b0});
    req0_addr = 8'h40; req0_data = 8'h18; req0_valid = 1'b1;
    wait_grant(p, s);
    req0_valid = 1'b0; req0_addr = 8'hAA; req0_data = 8'h55;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_start !== 1'b1 || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL single_grant: port=%0d start=%b addr=%h data=%h want port=%0d start=1 addr=%h data=%h",
               p, eng_start, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    tick(); tick(); tick();
    n_tests++;
    if (eng_addr !== 8'h40 || eng_data !== 8'h18 || eng_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: addr=%h data=%h start=%b want 40/18/0", eng_addr, eng_data, eng_start);
    end
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err || at !== s + eng_lat + 1) begin
      n_fail++;
      $display("FAIL single_done: port=%0d err=%b cyc=%0d want port=%0d err=%b cyc=%0d",
               p, er, at, e.port, e.err, s + eng_lat + 1);
    end
    t_low = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) begin t_low = cyc; break; end
    end
    n_tests++;
    if (t_low !== s + eng_lat + int'(GAP) + 1) begin
      n_fail++;
      $display("FAIL single_busy_fall: cyc=%0d want %0d", t_low, s + eng_lat + int'(GAP) + 1);
    end
  endtask

  task automatic test_contention();
    exp_t e; int p, s1, s2, at; bit er;
    do_reset();
    exp_q.push_back('{0, 8'h11, 8'hA1, 1'b0});
    exp_q.push_back('{1, 8'h22, 8'hB2, 1'b0});
    exp_q.push_back('{0, 8'h33, 8'hC3, 1'b0});
    req0_addr = 8'h11; req0_data = 8'hA1; req0_valid = 1'b1;
    req1_addr = 8'h22; req1_data = 8'hB2; req1_valid = 1'b1;
    wait_grant(p, s1);
    req0_addr = 8'h33; req0_data = 8'hC3;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL cont_grant1: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err) begin
      n_fail++;
      $display("FAIL cont_result1: port=%0d err=%b want %0d %b", p, er, e.port, e.err);
    end
    wait_grant(p, s2);
    req1_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL cont_grant2: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    n_tests++;
    if (s2 - s1 !== eng_lat + int'(GAP) + 2) begin
      n_fail++;
      $display("FAIL cont_spacing: got %0d want %0d", s2 - s1, eng_lat + int'(GAP) + 2);
    end
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err) begin
      n_fail++;
      $display("FAIL cont_result2: port=%0d err=%b want %0d %b", p, er, e.port, e.err);
    end
    wait_grant(p, s1);
    req0_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL cont_grant3: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err) begin
      n_fail++;
      $display("FAIL cont_result3: port=%0d err=%b want %0d %b", p, er, e.port, e.err);
    end
    for (int i = 0; i < int'(GAP) + 2; i++) tick();
  endtask

  task automatic test_nack_retry();
    exp_t e; int p, s, at, b_st, b_g, b_d, b_e; bit er;
    nack_plan = 1; nack_arm++;
    b_st = c_start; b_g = c_g0 + c_g1; b_d = c_d0 + c_d1; b_e = c_e0 + c_e1;
    exp_q.push_back('{0, 8'h05, 8'h5A, 1'b0});
    req0_addr = 8'h05; req0_data = 8'h5A; req0_valid = 1'b1;
    wait_grant(p, s);
    req0_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL nack_grant: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err || at !== s + 2 * eng_lat + int'(GAP) + 2) begin
      n_fail++;
      $display("FAIL nack_result: port=%0d err=%b cyc=%0d want %0d %b %0d",
               p, er, at, e.port, e.err, s + 2 * eng_lat + int'(GAP) + 2);
    end
    for (int i = 0; i < int'(GAP) + 3; i++) tick();
    n_tests++;
    if (c_start - b_st !== 2 || c_g0 + c_g1 - b_g !== 1 || c_d0 + c_d1 - b_d !== 1 || c_e0 + c_e1 - b_e !== 0
        || t_start - t_start_prev !== eng_lat + int'(GAP) + 1) begin
      n_fail++;
      $display("FAIL nack_counts: starts=%0d grants=%0d dones=%0d errs=%0d respace=%0d want 2 1 1 0 %0d",
               c_start - b_st, c_g0 + c_g1 - b_g, c_d0 + c_d1 - b_d, c_e0 + c_e1 - b_e,
               t_start - t_start_prev, eng_lat + int'(GAP) + 1);
    end
    nack_plan = 0; nack_arm++;
  endtask

  task automatic test_nack_exhausted();
    exp_t e; int p, s, at, b_st, b_g, b_d, b_e; bit er;
    int want_at;
    nack_forever = 1'b1;
    b_st = c_start; b_g = c_g0 + c_g1; b_d = c_d0 + c_d1; b_e = c_e1;
    exp_q.push_back('{1, 8'h07, 8'h70, 1'b1});
    req1_addr = 8'h07; req1_data = 8'h70; req1_valid = 1'b1;
    wait_grant(p, s);
    req1_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL exh_grant: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    want_at = s + 3 * eng_lat + 2 * (int'(GAP) + 1) + 1;
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err || at !== want_at) begin
      n_fail++;
      $display("FAIL exh_result: port=%0d err=%b cyc=%0d want %0d %b %0d", p, er, at, e.port, e.err, want_at);
    end
    for (int i = 0; i < int'(GAP) + 4; i++) tick();
    n_tests++;
    if (c_start - b_st !== 3 || c_g0 + c_g1 - b_g !== 1 || c_d0 + c_d1 - b_d !== 0 || c_e1 - b_e !== 1) begin
      n_fail++;
      $display("FAIL exh_counts: starts=%0d grants=%0d dones=%0d err1=%0d want 3 1 0 1",
               c_start - b_st, c_g0 + c_g1 - b_g, c_d0 + c_d1 - b_d, c_e1 - b_e);
    end
    nack_forever = 1'b0;
    exp_q.push_back('{1, 8'h08, 8'h80, 1'b0});
    req1_addr = 8'h08; req1_data = 8'h80; req1_valid = 1'b1;
    wait_grant(p, s);
    req1_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL exh_regrant: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err) begin
      n_fail++;
      $display("FAIL exh_reresult: port=%0d err=%b want %0d %b", p, er, e.port, e.err);
    end
    for (int i = 0; i < int'(GAP) + 2; i++) tick();
  endtask

  task automatic test_timeout();
    exp_t e; int p, s, at, b_st, low_seen, t_low; bit er;
    eng_mute = 1'b1;
    b_st = c_start;
    exp_q.push_back('{0, 8'h2C, 8'h01, 1'b1});
    req0_addr = 8'h2C; req0_data = 8'h01; req0_valid = 1'b1;
    wait_grant(p, s);
    req0_valid = 1'b0;
    busy_hold  = 1'b1;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL to_grant: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err || at !== s + int'(TO)) begin
      n_fail++;
      $display("FAIL to_err: port=%0d err=%b cyc=%0d want %0d %b %0d", p, er, at, e.port, e.err, s + int'(TO));
    end
    low_seen = 0;
    while (cyc < s + 40) begin
      tick();
      if (!busy) low_seen++;
    end
    n_tests++;
    if (low_seen !== 0) begin
      n_fail++;
      $display("FAIL to_hold_busy: idle cycles while engine busy=%0d want 0", low_seen);
    end
    busy_hold = 1'b0;
    t_low = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy) begin t_low = cyc; break; end
    end
    n_tests++;
    if (t_low !== s + 41 || c_start - b_st !== 1) begin
      n_fail++;
      $display("FAIL to_release: idle_cyc=%0d starts=%0d want %0d 1", t_low, c_start - b_st, s + 41);
    end
    eng_mute = 1'b0;
    // Engine completes on the very cycle the timeout would fire.
    eng_lat = int'(TO) - 1;
    exp_q.push_back('{0, 8'h2D, 8'h02, 1'b0});
    req0_addr = 8'h2D; req0_data = 8'h02; req0_valid = 1'b1;
    wait_grant(p, s);
    req0_valid = 1'b0;
    e = exp_q.pop_front();
    wait_result(p, er, at);
    n_tests++;
    if (p !== e.port || er !== e.err || at !== s + int'(TO)) begin
      n_fail++;
      $display("FAIL to_tie: port=%0d err=%b cyc=%0d want %0d %b %0d", p, er, at, e.port, e.err, s + int'(TO));
    end
    eng_lat = 10;
    for (int i = 0; i < int'(GAP) + 2; i++) tick();
  endtask

  task automatic test_reset_wait();
    exp_t e; int p, s, at, b_st, b_r; bit er;
    exp_q.push_back('{1, 8'h50, 8'h55, 1'b0});
    req1_addr = 8'h50; req1_data = 8'h55; req1_valid = 1'b1;
    wait_grant(p, s);
    req1_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
      n_fail++;
      $display("FAIL rst_grant: port=%0d addr=%h data=%h want %0d %h %h", p, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err, eng_start, busy} !== 8'h00
        || {eng_addr, eng_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_outputs: ctrl=%b addr=%h data=%h want 00000000 00 00",
               {req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err, eng_start, busy}, eng_addr, eng_data);
    end
    reset = 1'b0;
    b_st = c_start; b_r = c_d0 + c_d1 + c_e0 + c_e1;
    for (int i = 0; i < 25; i++) tick();
    n_tests++;
    if (c_start - b_st !== 0 || c_d0 + c_d1 + c_e0 + c_e1 - b_r !== 0) begin
      n_fail++;
      $display("FAIL rst_stray: starts=%0d results=%0d want 0 0", c_start - b_st, c_d0 + c_d1 + c_e0 + c_e1 - b_r);
    end
    exp_q.push_back('{0, 8'h61, 8'h66, 1'b0});
    exp_q.push_back('{1, 8'h62, 8'h77, 1'b0});
    req0_addr = 8'h61; req0_data = 8'h66; req0_valid = 1'b1;
    req1_addr = 8'h62; req1_data = 8'h77; req1_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_grant(p, s);
      if (p == 0) req0_valid = 1'b0;
      if (p == 1) req1_valid = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if (p !== e.port || eng_addr !== e.addr || eng_data !== e.data) begin
        n_fail++;
        $display("FAIL rst_regrant%0d: port=%0d addr=%h data=%h want %0d %h %h", k, p, eng_addr, eng_data, e.port, e.addr, e.data);
      end
      wait_result(p, er, at);
      n_tests++;
      if (p !== e.port || er !== e.err) begin
        n_fail++;
        $display("FAIL rst_result%0d: port=%0d err=%b want %0d %b", k, p, er, e.port, e.err);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_nack_retry();
    test_nack_exhausted();
    test_timeout();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
